stopwatch_lap_recorder: RTL and testbench

- Downstream consumer of the stopwatch counter chain. Captures the six live BCD time digits into a small lap memory on a lap-button press.
- Selects what goes to the display digit path: either the live time or one stored lap, chosen by a view button.
- Runs in the 10 Hz button/FSM domain, the same domain as the stopwatch start/stop FSM.

---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/btn_edge_detect.sv | 29 ++
 rtl/stopwatch_lap_recorder.sv | 134 +++++++++++++
 tb/tb_stopwatch_lap_recorder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// +----------------------------------------------------------------------------+
// | stopwatch_pkg                                                              |
// | Shared widths, lap-FSM state type and BCD digit packing for the stopwatch. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package stopwatch_pkg;

  localparam int BCD_W  = 4;
  localparam int DIGITS = 6;
  localparam int TIME_W = BCD_W * DIGITS;

  // LSB offsets of each digit inside the packed {min1,min0,sec1,sec0,ss1,ss0} word
  localparam int DIG_SSEC0_LSB = 0;
  localparam int DIG_SSEC1_LSB = 4;
  localparam int DIG_SEC0_LSB  = 8;
  localparam int DIG_SEC1_LSB  = 12;
  localparam int DIG_MIN0_LSB  = 16;
  localparam int DIG_MIN1_LSB  = 20;

  typedef enum logic [0:0] {
    LIVE = 1'b0,
    VIEW = 1'b1
  } lap_state_e;

endpackage

`default_nettype wire

// File: rtl/btn_edge_detect.sv
// +----------------------------------------------------------------------------+
// | btn_edge_detect                                                            |
// | Turns a debounced button level into a single-cycle rising-edge pulse.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module btn_edge_detect (
  input  logic clk_10Hz,
  input  logic rst,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  always_ff @(posedge clk_10Hz or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign pulse_o = level_i & ~level_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_lap_recorder.sv
// +----------------------------------------------------------------------------+
// | stopwatch_lap_recorder                                                     |
// | Records live BCD time into a lap memory and selects live/lap for display.  |
// | Optional macro LAP_WRAP_EN: ring-buffer laps (overwrite oldest when full). |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module stopwatch_lap_recorder
  import stopwatch_pkg::*;
#(
  parameter int LAP_DEPTH = 4,
  parameter int IDX_W     = 2
) (
  input  logic              clk_10Hz,
  input  logic              rst,
  input  logic [TIME_W-1:0] live_time,
  input  logic              btn_lap,
  input  logic              btn_view,
  input  logic              btn_clear,
  output logic [TIME_W-1:0] disp_time,
  output logic              view_mode,
  output logic [IDX_W-1:0]  view_idx,
  output logic [IDX_W:0]    lap_count,
  output logic              full
);

  localparam logic [IDX_W:0] C_DEPTH = (IDX_W+1)'(LAP_DEPTH);
`ifdef LAP_WRAP_EN
  localparam bit C_WRAP_EN = 1'b1;
`else
  localparam bit C_WRAP_EN = 1'b0;
`endif

  logic w_lap_p, w_view_p, w_clr_p;

  btn_edge_detect u_lap_edge   (.clk_10Hz(clk_10Hz), .rst(rst), .level_i(btn_lap),   .pulse_o(w_lap_p));
  btn_edge_detect u_view_edge  (.clk_10Hz(clk_10Hz), .rst(rst), .level_i(btn_view),  .pulse_o(w_view_p));
  btn_edge_detect u_clear_edge (.clk_10Hz(clk_10Hz), .rst(rst), .level_i(btn_clear), .pulse_o(w_clr_p));

  lap_state_e        state_q, state_d;
  logic [IDX_W:0]    lap_count_q, lap_count_d;
  logic [IDX_W-1:0]  view_idx_q, view_idx_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [TIME_W-1:0] mem_q [LAP_DEPTH];

  logic              w_full;
  logic              w_lap_wr;
  logic [IDX_W-1:0]  w_rd_ptr;

  assign w_full = (lap_count_q == C_DEPTH);

  always_comb begin
    state_d     = state_q;
    lap_count_d = lap_count_q;
    view_idx_d  = view_idx_q;
    wr_ptr_d    = wr_ptr_q;
    w_lap_wr    = 1'b0;
    if (w_clr_p) begin
      state_d     = LIVE;
      lap_count_d = '0;
      view_idx_d  = '0;
      wr_ptr_d    = '0;
    end else begin
      // View decisions look at the count before any same-cycle lap lands
      if (w_view_p) begin
        case (state_q)
          LIVE: begin
            if (lap_count_q != '0) begin
              state_d    = VIEW;
              view_idx_d = '0;
            end
          end
          VIEW: begin
            if ({1'b0, view_idx_q} == lap_count_q - (IDX_W+1)'(1)) begin
              state_d    = LIVE;
              view_idx_d = '0;
            end else begin
              view_idx_d = view_idx_q + IDX_W'(1);
            end
          end
          default: begin
            state_d    = LIVE;
            view_idx_d = '0;
          end
        endcase
      end
      if (w_lap_p && (!w_full || C_WRAP_EN)) begin
        w_lap_wr = 1'b1;
        wr_ptr_d = wr_ptr_q + IDX_W'(1);
        if (!w_full) begin
          lap_count_d = lap_count_q + (IDX_W+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_10Hz or posedge rst) begin
    if (rst) begin
      state_q     <= LIVE;
      lap_count_q <= '0;
      view_idx_q  <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      lap_count_q <= lap_count_d;
      view_idx_q  <= view_idx_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Lap storage carries no reset; contents are only visible through lap_count
  always_ff @(posedge clk_10Hz) begin
    if (w_lap_wr) begin
      mem_q[wr_ptr_q] <= live_time;
    end
  end

`ifdef LAP_WRAP_EN
  // Once full, wr_ptr points at the oldest entry, so index 0 stays the oldest lap
  assign w_rd_ptr = w_full ? (wr_ptr_q + view_idx_q) : view_idx_q;
`else
  assign w_rd_ptr = view_idx_q;
`endif

  assign disp_time = (state_q == VIEW) ? mem_q[w_rd_ptr] : live_time;
  assign view_mode = (state_q == VIEW);
  assign view_idx  = view_idx_q;
  assign lap_count = lap_count_q;
  assign full      = w_full;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_lap_recorder.sv
// +----------------------------------------------------------------------------+
// | tb_stopwatch_lap_recorder                                                  |
// | Self-checking bench: directed vector table, corner sequences, random run.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_stopwatch_lap_recorder;

  localparam int DEPTH = 4;

  logic        clk_10Hz;
  logic        rst;
  logic [23:0] live_time;
  logic        btn_lap, btn_view, btn_clear;
  logic [23:0] disp_time;
  logic        view_mode;
  logic [1:0]  view_idx;
  logic [2:0]  lap_count;
  logic        full;

  stopwatch_lap_recorder #(.LAP_DEPTH(DEPTH), .IDX_W(2)) dut (
    .clk_10Hz (clk_10Hz),
    .rst      (rst),
    .live_time(live_time),
    .btn_lap  (btn_lap),
    .btn_view (btn_view),
    .btn_clear(btn_clear),
    .disp_time(disp_time),
    .view_mode(view_mode),
    .view_idx (view_idx),
    .lap_count(lap_count),
    .full     (full)
  );

  initial clk_10Hz = 1'b0;
  always #5 clk_10Hz = ~clk_10Hz;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: list of stored laps, oldest first
  logic [23:0] m_laps[$];
  bit          m_view;
  int          m_idx;
  bit          p_lap, p_view, p_clr;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_laps.delete();
    m_view = 0;
    m_idx  = 0;
    p_lap  = 0;
    p_view = 0;
    p_clr  = 0;
  endtask

  task automatic model_step(input bit l, input bit v, input bit c, input logic [23:0] t);
    bit lp, vp, cp;
    int pre;
    lp = l && !p_lap;
    vp = v && !p_view;
    cp = c && !p_clr;
    p_lap = l; p_view = v; p_clr = c;
    if (cp) begin
      m_laps.delete();
      m_view = 0;
      m_idx  = 0;
    end else begin
      pre = m_laps.size();
      if (vp) begin
        if (!m_view) begin
          if (pre != 0) begin m_view = 1; m_idx = 0; end
        end else if (m_idx == pre - 1) begin
          m_view = 0; m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (lp) begin
        if (pre < DEPTH) m_laps.push_back(t);
`ifdef LAP_WRAP_EN
        else begin
          void'(m_laps.pop_front());
          m_laps.push_back(t);
        end
`endif
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [23:0] e_disp;
    e_disp = m_view ? m_laps[m_idx] : live_time;
    cmp({tag, ".disp"}, 32'(disp_time), 32'(e_disp));
    cmp({tag, ".view_mode"}, 32'(view_mode), 32'(m_view));
    cmp({tag, ".view_idx"}, 32'(view_idx), 32'(m_idx));
    cmp({tag, ".lap_count"}, 32'(lap_count), 32'(m_laps.size()));
    cmp({tag, ".full"}, 32'(full), 32'(m_laps.size() == DEPTH));
  endtask

  task automatic cyc(input bit l, input bit v, input bit c, input logic [23:0] t);
    @(negedge clk_10Hz);
    btn_lap = l; btn_view = v; btn_clear = c; live_time = t;
    @(posedge clk_10Hz);
    model_step(l, v, c, t);
    #1;
  endtask

  typedef struct {
    bit          lap, view, clr;
    logic [23:0] lt;
    logic [23:0] disp;
    bit          vm;
    logic [1:0]  idx;
    logic [2:0]  cnt;
    bit          full;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{0, 0, 0, 24'h012345, 24'h012345, 0, 2'd0, 3'd0, 0};
    tbl[1]  = '{0, 1, 0, 24'h012345, 24'h012345, 0, 2'd0, 3'd0, 0};
    tbl[2]  = '{0, 0, 0, 24'h000512, 24'h000512, 0, 2'd0, 3'd0, 0};
    tbl[3]  = '{1, 0, 0, 24'h000512, 24'h000512, 0, 2'd0, 3'd1, 0};
    tbl[4]  = '{0, 0, 0, 24'h001034, 24'h001034, 0, 2'd0, 3'd1, 0};
    tbl[5]  = '{1, 0, 0, 24'h001034, 24'h001034, 0, 2'd0, 3'd2, 0};
    tbl[6]  = '{0, 0, 0, 24'h002000, 24'h002000, 0, 2'd0, 3'd2, 0};
    tbl[7]  = '{0, 1, 0, 24'h002000, 24'h000512, 1, 2'd0, 3'd2, 0};
    tbl[8]  = '{0, 0, 0, 24'h002000, 24'h000512, 1, 2'd0, 3'd2, 0};
    tbl[9]  = '{0, 1, 0, 24'h002000, 24'h001034, 1, 2'd1, 3'd2, 0};
    tbl[10] = '{0, 0, 0, 24'h002001, 24'h001034, 1, 2'd1, 3'd2, 0};
    tbl[11] = '{0, 1, 0, 24'h002001, 24'h002001, 0, 2'd0, 3'd2, 0};
    tbl[12] = '{0, 0, 0, 24'h002002, 24'h002002, 0, 2'd0, 3'd2, 0};
    tbl[13] = '{0, 0, 1, 24'h002002, 24'h002002, 0, 2'd0, 3'd0, 0};

    btn_lap = 0; btn_view = 0; btn_clear = 0; live_time = 24'h012345;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk_10Hz);
    #1;
    cmp("reset.disp", 32'(disp_time), 32'h012345);
    cmp("reset.view_mode", 32'(view_mode), 0);
    cmp("reset.lap_count", 32'(lap_count), 0);
    cmp("reset.full", 32'(full), 0);
    @(negedge clk_10Hz);
    rst = 0;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].lap, tbl[i].view, tbl[i].clr, tbl[i].lt);
      cmp($sformatf("tbl%0d.disp", i), 32'(disp_time), 32'(tbl[i].disp));
      cmp($sformatf("tbl%0d.view_mode", i), 32'(view_mode), 32'(tbl[i].vm));
      cmp($sformatf("tbl%0d.view_idx", i), 32'(view_idx), 32'(tbl[i].idx));
      cmp($sformatf("tbl%0d.lap_count", i), 32'(lap_count), 32'(tbl[i].cnt));
      cmp($sformatf("tbl%0d.full", i), 32'(full), 32'(tbl[i].full));
    end
    cyc(0, 0, 0, 24'h000000);

    // Held lap button records exactly once
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 24'h000077);
    cyc(0, 0, 0, 24'h000078);
    cmp("hold.lap_count", 32'(lap_count), 1);
    check_all("hold");
    cyc(0, 0, 1, 24'h000078);
    cyc(0, 0, 0, 24'h000078);

    // Five laps into a four-entry memory
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 0, 24'(i));
      cyc(0, 0, 0, 24'h009999);
    end
    cmp("five.lap_count", 32'(lap_count), 4);
    cmp("five.full", 32'(full), 1);
    for (int i = 0; i < 4; i++) begin
      int base;
`ifdef LAP_WRAP_EN
      base = 2;
`else
      base = 1;
`endif
      cyc(0, 1, 0, 24'h009999);
      cmp($sformatf("five.view%0d", i), 32'(disp_time), 32'(base + i));
      cyc(0, 0, 0, 24'h009999);
    end
    // Clear and lap together while viewing
    cmp("cl.pre_view_mode", 32'(view_mode), 1);
    cyc(1, 0, 1, 24'h004444);
    cmp("cl.view_mode", 32'(view_mode), 0);
    cmp("cl.lap_count", 32'(lap_count), 0);
    check_all("cl");
    cyc(0, 0, 0, 24'h004445);
    cyc(0, 1, 0, 24'h004446);
    cmp("empty_view.view_mode", 32'(view_mode), 0);
    cyc(0, 0, 0, 24'h004446);

    // Asynchronous reset while viewing three laps
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 24'h000100 + 24'(i));
      cyc(0, 0, 0, 24'h000200);
    end
    cyc(0, 1, 0, 24'h000300);
    cmp("arst.pre_view_mode", 32'(view_mode), 1);
    @(negedge clk_10Hz);
    btn_view = 0;
    live_time = 24'h031415;
    #1 rst = 1;
    #1;
    cmp("arst.disp", 32'(disp_time), 32'h031415);
    cmp("arst.view_mode", 32'(view_mode), 0);
    cmp("arst.view_idx", 32'(view_idx), 0);
    cmp("arst.lap_count", 32'(lap_count), 0);
    cmp("arst.full", 32'(full), 0);
    model_reset();
    @(negedge clk_10Hz);
    rst = 0;

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 25) == 0, 24'($urandom));
      check_all($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
